// File: rtl/select_encode_sb.sv
// Register select-and-encode unit: latched IR, gra/grb/grc field select, one-hot
// register enables, sign-extended C constant. Define SELENC_SCOREBOARD_EN to add the pending-write scoreboard and stall.
module select_encode_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RA_LSB   = 23,
  parameter int unsigned RB_LSB   = 19,
  parameter int unsigned RC_LSB   = 15,
  parameter int unsigned CONST_W  = 19,
  localparam int unsigned RIDX_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                ir_load,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  input  logic                sb_set,
  input  logic                sb_clr,
  input  logic [RIDX_W-1:0]   sb_clr_idx,
  output logic [NUM_REGS-1:0] r_in_en,
  output logic [NUM_REGS-1:0] r_out_en,
  output logic                r0_zero,
  output logic [DATA_W-1:0]   const_c,
  output logic                stall,
  output logic [NUM_REGS-1:0] sb_pending,
  output logic                sel_err
);

  logic [DATA_W-1:0]   r_ir;
  logic                r_sel_err;
  logic [RIDX_W-1:0]   w_sel_idx;
  logic                w_sel_valid;
  logic                w_access;
  logic                w_multi_sel;
  logic                w_r0_base;
  logic [NUM_REGS-1:0] w_onehot;
  logic                w_unused;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ir      <= '0;
      r_sel_err <= 1'b0;
    end else begin
      if (ir_load) r_ir <= ir_in;
      if (w_multi_sel) r_sel_err <= 1'b1;
    end
  end

  // NOTE: the combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    w_sel_idx = '0;
    if (gra)      w_sel_idx = r_ir[RA_LSB +: RIDX_W];
    else if (grb) w_sel_idx = r_ir[RB_LSB +: RIDX_W];
    else if (grc) w_sel_idx = r_ir[RC_LSB +: RIDX_W];
  end

  assign w_sel_valid = gra | grb | grc;
  assign w_access    = rin | rout | baout;
  assign w_multi_sel = (gra & grb) | (gra & grc) | (grb & grc);
  assign w_onehot    = NUM_REGS'(1) << w_sel_idx;
  assign w_r0_base   = baout && (w_sel_idx == '0);

`ifdef SELENC_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic                w_sb_set_ok;

  assign w_sb_set_ok = sb_set & w_sel_valid & ~stall;

  // The set is written after the clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pending <= '0;
    end else begin
      if (sb_clr)      r_pending[sb_clr_idx] <= 1'b0;
      if (w_sb_set_ok) r_pending[w_sel_idx]  <= 1'b1;
    end
  end

  assign stall      = w_sel_valid & w_access & r_pending[w_sel_idx];
  assign sb_pending = r_pending;
  assign w_unused   = ^r_ir;
`else
  assign stall      = 1'b0;
  assign sb_pending = '0;
  assign w_unused   = ^{r_ir, sb_set, sb_clr, sb_clr_idx};
`endif

  assign r_in_en  = (w_sel_valid & rin & ~stall) ? w_onehot : '0;
  assign r_out_en = (w_sel_valid & (rout | baout) & ~stall & ~w_r0_base) ? w_onehot : '0;
  assign r0_zero  = w_sel_valid & ~stall & w_r0_base;
  assign const_c  = {{(DATA_W-CONST_W){r_ir[CONST_W-1]}}, r_ir[CONST_W-1:0]};
  assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_select_encode_sb.sv
// Directed bench for select_encode_sb; scoreboard expectations follow SELENC_SCOREBOARD_EN.
module tb_select_encode_sb;

`ifdef SELENC_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n;
  logic        ir_load;
  logic [31:0] ir_in;
  logic        gra, grb, grc, rin, rout, baout;
  logic        sb_set, sb_clr;
  logic [3:0]  sb_clr_idx;
  logic [15:0] r_in_en, r_out_en, sb_pending;
  logic        r0_zero, stall, sel_err;
  logic [31:0] const_c;

  int n_checks = 0;
  int n_fail   = 0;

  select_encode_sb dut (
    .clk(clk), .clr_n(clr_n), .ir_load(ir_load), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .sb_set(sb_set), .sb_clr(sb_clr), .sb_clr_idx(sb_clr_idx),
    .r_in_en(r_in_en), .r_out_en(r_out_en), .r0_zero(r0_zero),
    .const_c(const_c), .stall(stall), .sb_pending(sb_pending), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
    sb_set = 0; sb_clr = 0; sb_clr_idx = 0; ir_load = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ir(input logic [31:0] v);
    ir_in = v; ir_load = 1;
    tick();
    ir_load = 0;
  endtask

  task automatic test_reset();
    idle(); ir_in = '0; clr_n = 0;
    #3;
    n_checks++; if ({r_in_en, r_out_en, sb_pending} !== 48'h0) begin n_fail++; $display("FAIL reset_en act=%h exp=0", {r_in_en, r_out_en, sb_pending}); end
    n_checks++; if ({r0_zero, stall, sel_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags act=%b exp=000", {r0_zero, stall, sel_err}); end
    n_checks++; if (const_c !== 32'h0) begin n_fail++; $display("FAIL reset_const act=%h exp=0", const_c); end
    @(negedge clk); clr_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write_decode();
    load_ir(32'h0A980000);
    gra = 1; rin = 1; #1;
    n_checks++; if (r_in_en !== 16'h0020) begin n_fail++; $display("FAIL wr_ra_rin act=%h exp=0020", r_in_en); end
    n_checks++; if (r_out_en !== 16'h0000) begin n_fail++; $display("FAIL wr_ra_out act=%h exp=0000", r_out_en); end
    idle(); grb = 1; rout = 1; #1;
    n_checks++; if (r_out_en !== 16'h0008) begin n_fail++; $display("FAIL rd_rb act=%h exp=0008", r_out_en); end
    n_checks++; if (r_in_en !== 16'h0000) begin n_fail++; $display("FAIL rd_rb_in act=%h exp=0000", r_in_en); end
    idle(); grc = 1; rout = 1; #1;
    n_checks++; if (r_out_en !== 16'h0001) begin n_fail++; $display("FAIL rd_rc act=%h exp=0001", r_out_en); end
    idle(); rin = 1; rout = 1; #1;
    n_checks++; if ({r_in_en, r_out_en} !== 32'h0) begin n_fail++; $display("FAIL no_sel act=%h exp=0", {r_in_en, r_out_en}); end
    idle();
  endtask

  task automatic test_r0_base();
    load_ir(32'h00180000);
    gra = 1; baout = 1; #1;
    n_checks++; if (r_out_en !== 16'h0000 || r0_zero !== 1'b1) begin n_fail++; $display("FAIL r0_baout act=%h/%b exp=0000/1", r_out_en, r0_zero); end
    idle(); gra = 1; rout = 1; #1;
    n_checks++; if (r_out_en !== 16'h0001 || r0_zero !== 1'b0) begin n_fail++; $display("FAIL r0_rout act=%h/%b exp=0001/0", r_out_en, r0_zero); end
    idle(); grb = 1; baout = 1; #1;
    n_checks++; if (r_out_en !== 16'h0008 || r0_zero !== 1'b0) begin n_fail++; $display("FAIL r3_baout act=%h/%b exp=0008/0", r_out_en, r0_zero); end
    idle();
  endtask

  task automatic test_const();
    load_ir(32'h0007FFFF); #1;
    n_checks++; if (const_c !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL const_neg act=%h exp=FFFFFFFF", const_c); end
    load_ir(32'h0003FFFF); #1;
    n_checks++; if (const_c !== 32'h0003FFFF) begin n_fail++; $display("FAIL const_pos act=%h exp=0003FFFF", const_c); end
  endtask

  task automatic test_load_with_strobes();
    load_ir(32'h0A980000);
    ir_in = 32'h00180000; ir_load = 1; gra = 1; rin = 1; #1;
    n_checks++; if (r_in_en !== 16'h0020) begin n_fail++; $display("FAIL old_ir act=%h exp=0020", r_in_en); end
    tick(); ir_load = 0; #1;
    n_checks++; if (r_in_en !== 16'h0001) begin n_fail++; $display("FAIL new_ir act=%h exp=0001", r_in_en); end
    idle();
  endtask

  task automatic test_scoreboard();
    load_ir(32'h02A80000);
    gra = 1; sb_set = 1; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sb_set_nostall act=%b exp=0", stall); end
    tick(); idle(); #1;
    n_checks++; if (sb_pending !== (SB_EN ? 16'h0020 : 16'h0000)) begin n_fail++; $display("FAIL sb_pend_set act=%h exp=%h", sb_pending, SB_EN ? 16'h0020 : 16'h0000); end
    grb = 1; rout = 1; #1;
    n_checks++; if (stall !== SB_EN) begin n_fail++; $display("FAIL sb_stall act=%b exp=%b", stall, SB_EN); end
    n_checks++; if (r_out_en !== (SB_EN ? 16'h0000 : 16'h0020)) begin n_fail++; $display("FAIL sb_stall_out act=%h exp=%h", r_out_en, SB_EN ? 16'h0000 : 16'h0020); end
    sb_clr = 1; sb_clr_idx = 4'd5; #1;
    n_checks++; if (stall !== SB_EN) begin n_fail++; $display("FAIL sb_clr_same act=%b exp=%b", stall, SB_EN); end
    tick(); sb_clr = 0; #1;
    n_checks++; if (stall !== 1'b0 || r_out_en !== 16'h0020) begin n_fail++; $display("FAIL sb_release act=%b/%h exp=0/0020", stall, r_out_en); end
    n_checks++; if (sb_pending !== 16'h0000) begin n_fail++; $display("FAIL sb_pend_clr act=%h exp=0000", sb_pending); end
    idle(); sb_set = 1;
    tick(); idle(); #1;
    n_checks++; if (sb_pending !== 16'h0000) begin n_fail++; $display("FAIL sb_set_nosel act=%h exp=0000", sb_pending); end
    gra = 1; sb_set = 1; sb_clr = 1; sb_clr_idx = 4'd5;
    tick(); idle(); #1;
    n_checks++; if (sb_pending !== (SB_EN ? 16'h0020 : 16'h0000)) begin n_fail++; $display("FAIL sb_collide act=%h exp=%h", sb_pending, SB_EN ? 16'h0020 : 16'h0000); end
    sb_clr = 1; sb_clr_idx = 4'd3;
    tick(); idle(); #1;
    n_checks++; if (sb_pending !== (SB_EN ? 16'h0020 : 16'h0000)) begin n_fail++; $display("FAIL sb_clr_other act=%h exp=%h", sb_pending, SB_EN ? 16'h0020 : 16'h0000); end
    sb_clr = 1; sb_clr_idx = 4'd5;
    tick(); idle(); #1;
    n_checks++; if (sb_pending !== 16'h0000) begin n_fail++; $display("FAIL sb_clr5 act=%h exp=0000", sb_pending); end
  endtask

  task automatic test_priority();
    load_ir(32'h0A980000);
    gra = 1; grb = 1; rin = 1; #1;
    n_checks++; if (r_in_en !== 16'h0020) begin n_fail++; $display("FAIL prio_ra act=%h exp=0020", r_in_en); end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_pre act=%b exp=0", sel_err); end
    idle(); grb = 1; grc = 1; rout = 1; #1;
    n_checks++; if (r_out_en !== 16'h0008) begin n_fail++; $display("FAIL prio_rb act=%h exp=0008", r_out_en); end
    tick(); idle(); tick(); tick(); #1;
    n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_sticky act=%b exp=1", sel_err); end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 16; i++) begin
      load_ir((32'(i) << 23) | 32'h0007FFFF);
      gra = 1; sb_set = 1;
      tick(); idle();
    end
    #1;
    n_checks++; if (sb_pending !== (SB_EN ? 16'hFFFF : 16'h0000)) begin n_fail++; $display("FAIL sb_all act=%h exp=%h", sb_pending, SB_EN ? 16'hFFFF : 16'h0000); end
    gra = 1; rin = 1; #1;
    n_checks++; if (stall !== SB_EN) begin n_fail++; $display("FAIL sb_all_stall act=%b exp=%b", stall, SB_EN); end
    idle(); gra = 1; rout = 1;
    #1; clr_n = 0; #1;
    n_checks++; if (sb_pending !== 16'h0000 || stall !== 1'b0 || sel_err !== 1'b0) begin n_fail++; $display("FAIL async_rst act=%h/%b/%b exp=0000/0/0", sb_pending, stall, sel_err); end
    n_checks++; if (r_out_en !== 16'h0001 || r_in_en !== 16'h0000 || const_c !== 32'h0) begin n_fail++; $display("FAIL async_rst_ir act=%h/%h/%h exp=0001/0000/0", r_out_en, r_in_en, const_c); end
    idle(); #1;
    n_checks++; if ({r_in_en, r_out_en, r0_zero} !== 33'h0) begin n_fail++; $display("FAIL async_rst_idle act=%h exp=0", {r_in_en, r_out_en, r0_zero}); end
    @(negedge clk); clr_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_decode();
    test_r0_base();
    test_const();
    test_load_with_strobes();
    test_scoreboard();
    test_priority();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
